// File: rtl/noc_traffic_pe.sv
// Synthetic NoC traffic endpoint: injects timestamped packets to a
// pattern-chosen peer and gathers latency/misroute statistics on receive.
module noc_traffic_pe #(
  parameter int    address      = 0,
  parameter int    numPE        = 4,
  parameter int    AddressWidth = 2,
  parameter int    DataWidth    = 32,
  parameter int    TotalWidth   = 34,
  parameter int    PktLmit      = 100,
  parameter string Pattern      = "RANDOM"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TotalWidth-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic [TotalWidth-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  input  logic                  done
);

  typedef logic [AddressWidth-1:0] addr_t;
  typedef logic [AddressWidth:0]   addr_w_t;

  localparam int ModeRandom     = 0;
  localparam int ModeNeighbor   = 1;
  localparam int ModeComplement = 2;
  localparam int Mode =
    (Pattern == "NEIGHBOR")   ? ModeNeighbor   :
    (Pattern == "COMPLEMENT") ? ModeComplement :
    ModeRandom;

  // Inputs never reach 2*numPE, so one conditional subtract is a full mod.
  function automatic addr_t wrap(input addr_w_t v);
    if (v >= addr_w_t'(numPE))
      return addr_t'(v - addr_w_t'(numPE));
    return v[AddressWidth-1:0];
  endfunction

  function automatic addr_t step(input addr_t a);
    return wrap({1'b0, a} + addr_w_t'(1));
  endfunction

  localparam addr_t Self    = addr_t'(address);
  localparam addr_t Nbr     = step(Self);
  localparam addr_t CompRaw = wrap({1'b0, ~Self});
  localparam addr_t Comp    = (CompRaw == Self) ? Nbr : CompRaw;
  localparam logic [15:0] Seed = 16'hACE1 ^ 16'(address);

  logic [DataWidth-1:0] cyc;
  logic [31:0]          tx_count;
  logic [31:0]          rx_count;
  logic [47:0]          lat_sum;
  logic [DataWidth-1:0] lat_max;
  logic                 misroute;
  logic                 halted;
  logic [15:0]          lfsr;

  logic [15:0]          lfsr_nxt;
  logic [31:0]          tx_nxt;
  logic                 xfer;
  logic                 load;
  addr_t                rnd;
  addr_t                dest;
  logic [DataWidth-1:0] lat;

  always_comb begin
    xfer     = o_data_valid & i_data_ready;
    lfsr_nxt = lfsr;
    if (xfer)
      lfsr_nxt = {lfsr[14:0],
                  lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    tx_nxt = tx_count + 32'(xfer);
    load   = !halted && !done
           && (tx_nxt < 32'(PktLmit))
           && (xfer || !o_data_valid);
    rnd  = wrap({1'b0, lfsr_nxt[AddressWidth-1:0]});
    dest = (rnd == Self) ? step(rnd) : rnd;
    if (Mode == ModeNeighbor)
      dest = Nbr;
    else if (Mode == ModeComplement)
      dest = Comp;
    lat = cyc - i_data[DataWidth-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc          <= '0;
      tx_count     <= '0;
      rx_count     <= '0;
      lat_sum      <= '0;
      lat_max      <= '0;
      misroute     <= 1'b0;
      halted       <= 1'b0;
      lfsr         <= Seed;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_data_ready <= 1'b0;
    end else begin
      cyc          <= cyc + DataWidth'(1);
      o_data_ready <= 1'b1;
      lfsr         <= lfsr_nxt;
      tx_count     <= tx_nxt;
      if (done)
        halted <= 1'b1;
      // Timestamp is the counter value of the cycle the flit appears.
      if (load) begin
        o_data_valid <= 1'b1;
        o_data       <= {dest, cyc + DataWidth'(1)};
      end else if (xfer || done) begin
        o_data_valid <= 1'b0;
      end
      if (i_data_valid) begin
        if (rx_count != '1)
          rx_count <= rx_count + 32'd1;
        lat_sum <= lat_sum + 48'(lat);
        if (lat > lat_max)
          lat_max <= lat;
        if (i_data[TotalWidth-1:DataWidth] != Self)
          misroute <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_pe.sv
// Directed bench for noc_traffic_pe: three instances cover the
// NEIGHBOR, RANDOM and COMPLEMENT patterns plus the receive statistics.
module tb_noc_traffic_pe;

  logic clk;
  int   tests  = 0;
  int   failed = 0;

  logic        nb_rst, nb_ivalid, nb_ordy, nb_ovalid, nb_irdy, nb_done;
  logic [33:0] nb_idata, nb_odata;
  logic        rnd_rst, rnd_ivalid, rnd_ordy, rnd_ovalid, rnd_irdy, rnd_done;
  logic [33:0] rnd_idata, rnd_odata;
  logic        rx_rst, rx_ivalid, rx_ordy, rx_ovalid, rx_irdy, rx_done;
  logic [33:0] rx_idata, rx_odata;

  logic [31:0] rx_cyc;
  logic [1:0]  rnd1 [100];
  logic [1:0]  rnd2 [100];

  noc_traffic_pe #(.address(2), .Pattern("NEIGHBOR")) u_nb (
    .clk(clk), .rst(nb_rst),
    .i_data(nb_idata), .i_data_valid(nb_ivalid),
    .o_data_ready(nb_ordy), .o_data(nb_odata),
    .o_data_valid(nb_ovalid), .i_data_ready(nb_irdy),
    .done(nb_done)
  );

  noc_traffic_pe #(.address(0), .Pattern("RANDOM")) u_rnd (
    .clk(clk), .rst(rnd_rst),
    .i_data(rnd_idata), .i_data_valid(rnd_ivalid),
    .o_data_ready(rnd_ordy), .o_data(rnd_odata),
    .o_data_valid(rnd_ovalid), .i_data_ready(rnd_irdy),
    .done(rnd_done)
  );

  noc_traffic_pe #(.address(1), .Pattern("COMPLEMENT")) u_rx (
    .clk(clk), .rst(rx_rst),
    .i_data(rx_idata), .i_data_valid(rx_ivalid),
    .o_data_ready(rx_ordy), .o_data(rx_odata),
    .o_data_valid(rx_ovalid), .i_data_ready(rx_irdy),
    .done(rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter for the receive-side timestamps.
  always @(posedge clk)
    rx_cyc <= rx_rst ? 32'd0 : rx_cyc + 32'd1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rnd_run(input bit second);
    int nv;
    nv = 0;
    rnd_rst = 1'b1;
    rnd_irdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rnd_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rnd_ovalid) nv++;
      if (second) rnd2[i] = rnd_odata[33:32];
      else        rnd1[i] = rnd_odata[33:32];
    end
    chk("rnd_valid_run", 64'(nv), 64'd0);
    @(negedge clk);
    chk("rnd_valid_end", 64'(rnd_ovalid), 64'd0);
    chk("rnd_tx_count", 64'(u_rnd.tx_count), 64'd100);
  endtask

  initial begin
    int bad_d, bad_p, bad, ntx, k, n;
    logic [33:0] held;

    nb_rst = 1'b1;  nb_idata = '0;  nb_ivalid = 1'b0;
    nb_irdy = 1'b0; nb_done = 1'b0;
    rnd_rst = 1'b1; rnd_idata = '0; rnd_ivalid = 1'b0;
    rnd_irdy = 1'b0; rnd_done = 1'b0;
    rx_rst = 1'b1;  rx_idata = '0;  rx_ivalid = 1'b0;
    rx_irdy = 1'b0; rx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_valid", 64'(nb_ovalid), 64'd0);
    chk("rst_odata", 64'(nb_odata), 64'd0);
    chk("rst_ready", 64'(nb_ordy), 64'd0);
    chk("rst_tx", 64'(u_nb.tx_count), 64'd0);
    chk("rst_seed0", 64'(u_rnd.lfsr), 64'hACE1);
    chk("rst_seed1", 64'(u_rx.lfsr), 64'hACE0);
    chk("rst_rx_count", 64'(u_rx.rx_count), 64'd0);

    // NEIGHBOR, ready held high
    nb_irdy = 1'b1;
    nb_rst = 1'b0;
    bad_d = 0;
    bad_p = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (!nb_ovalid || nb_odata[33:32] != 2'd3) bad_d++;
      if (nb_odata[31:0] != 32'(i)) bad_p++;
    end
    chk("nb_dest", 64'(bad_d), 64'd0);
    chk("nb_payload", 64'(bad_p), 64'd0);
    @(negedge clk);
    chk("nb_valid_101", 64'(nb_ovalid), 64'd0);
    chk("nb_tx_count", 64'(u_nb.tx_count), 64'd100);
    repeat (3) @(negedge clk);
    chk("nb_valid_stays0", 64'(nb_ovalid), 64'd0);

    // Backpressure: 5-cycle stall on flit 21
    nb_rst = 1'b1;
    @(negedge clk);
    nb_rst = 1'b0;
    ntx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nb_ovalid) ntx++;
    end
    @(negedge clk);
    held = nb_odata;
    chk("bp_held_payload", 64'(held), {30'd0, 2'd3, 32'd21});
    nb_irdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!nb_ovalid || nb_odata !== held) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    nb_irdy = 1'b1;
    ntx++;
    @(negedge clk);
    chk("bp_resume", 64'(nb_odata), {30'd0, 2'd3, 32'd27});
    k = 0;
    while (nb_ovalid && k < 200) begin
      ntx++;
      k++;
      @(negedge clk);
    end
    chk("bp_budget", 64'(k < 200), 64'd1);
    chk("bp_transfers", 64'(ntx), 64'd100);
    chk("bp_tx_count", 64'(u_nb.tx_count), 64'd100);

    // RANDOM from address 0, twice
    rnd_run(1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++)
      if (rnd1[i] == 2'd0) bad++;
    chk("rnd_no_self", 64'(bad), 64'd0);
    chk("rnd_dest0", 64'(rnd1[0]), 64'd1);
    chk("rnd_dest1", 64'(rnd1[1]), 64'd3);
    chk("rnd_dest2", 64'(rnd1[2]), 64'd3);
    rnd_run(1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++)
      if (rnd1[i] !== rnd2[i]) bad++;
    chk("rnd_repeat", 64'(bad), 64'd0);

    // Receive path on address 1 (tx side stalled)
    rx_rst = 1'b0;
    @(negedge clk);
    chk("cmp_first_flit", 64'(rx_odata), {30'd0, 2'd2, 32'd1});
    for (int i = 0; i < 3; i++) begin
      rx_idata = {2'd1, rx_cyc - 32'd7};
      rx_ivalid = 1'b1;
      @(negedge clk);
    end
    rx_ivalid = 1'b0;
    @(negedge clk);
    chk("rx_count", 64'(u_rx.rx_count), 64'd3);
    chk("rx_lat_max", 64'(u_rx.lat_max), 64'd7);
    chk("rx_lat_sum", 64'(u_rx.lat_sum), 64'd21);
    chk("rx_misroute0", 64'(u_rx.misroute), 64'd0);
    chk("rx_ready", 64'(rx_ordy), 64'd1);

    rx_idata = {2'd3, rx_cyc};
    rx_ivalid = 1'b1;
    @(negedge clk);
    rx_ivalid = 1'b0;
    @(negedge clk);
    chk("rx_misroute1", 64'(u_rx.misroute), 64'd1);
    rx_idata = {2'd1, rx_cyc + 32'd1};
    rx_ivalid = 1'b1;
    @(negedge clk);
    rx_ivalid = 1'b0;
    @(negedge clk);
    chk("rx_misroute_sticky", 64'(u_rx.misroute), 64'd1);
    chk("rx_lat_max_wrap", 64'(u_rx.lat_max), 64'hFFFF_FFFF);
    chk("rx_lat_sum_wrap", 64'(u_rx.lat_sum), 64'h1_0000_0014);
    chk("rx_count5", 64'(u_rx.rx_count), 64'd5);
    chk("tx_hold_stall", 64'(rx_odata), {30'd0, 2'd2, 32'd1});

    rx_irdy = 1'b1;
    rx_rst = 1'b1;
    @(negedge clk);
    chk("rst2_misroute", 64'(u_rx.misroute), 64'd0);
    chk("rst2_lat_sum", 64'(u_rx.lat_sum), 64'd0);
    chk("rst2_lat_max", 64'(u_rx.lat_max), 64'd0);
    chk("rst2_tx", 64'(u_rx.tx_count), 64'd0);
    chk("rst2_valid", 64'(rx_ovalid), 64'd0);

    // done after 10 transfers
    rx_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_ovalid) n++;
    end
    rx_done = 1'b1;
    @(negedge clk);
    chk("done_valid", 64'(rx_ovalid), 64'd0);
    chk("done_tx", 64'(u_rx.tx_count), 64'd10);
    chk("done_seen", 64'(n), 64'd10);
    chk("done_ready", 64'(rx_ordy), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_hold", 64'(rx_ovalid), 64'd0);

    // Mid-stream reset then restart
    rx_done = 1'b0;
    rx_rst = 1'b1;
    @(negedge clk);
    rx_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("ms_tx_before", 64'(u_rx.tx_count), 64'd4);
    rx_rst = 1'b1;
    @(negedge clk);
    chk("ms_tx", 64'(u_rx.tx_count), 64'd0);
    chk("ms_cyc", 64'(u_rx.cyc), 64'd0);
    chk("ms_valid", 64'(rx_ovalid), 64'd0);
    rx_rst = 1'b0;
    @(negedge clk);
    chk("ms_restart", 64'(rx_odata), {30'd0, 2'd2, 32'd1});
    chk("ms_restart_v", 64'(rx_ovalid), 64'd1);
    @(negedge clk);
    chk("ms_tx_after", 64'(u_rx.tx_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/noc_traffic_pe.md
Name: noc_traffic_pe

Overview:
- Synthetic traffic-generator and sink endpoint for one processing-element port of the hierarchical NoC; one instance per NoC port, all on the 100 MHz fabric clock.
- Injects a fixed number of timestamped, addressed packets under a selectable destination pattern through a valid/ready interface.
- Accepts packets from the NoC unconditionally and accumulates receive statistics in internal registers.

Parameters:
- address, 0, this PE's own NoC address (0..numPE-1).
- numPE, 4, number of PEs on the NoC; must be ≥2.
- AddressWidth, 2, destination field width; equals $clog2(numPE).
- DataWidth, 32, payload width.
- TotalWidth, 34, flit width; must equal DataWidth+AddressWidth.
- PktLmit, 100, number of packets injected after reset.
- Pattern, "RANDOM", destination pattern: "RANDOM", "NEIGHBOR" or "COMPLEMENT".

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_data  in  TotalWidth  flit from the NoC.
- i_data_valid  in  1  i_data is valid this cycle.
- o_data_ready  out  1  PE can accept a flit.
- o_data  out  TotalWidth  flit to the NoC.
- o_data_valid  out  1  o_data is valid.
- i_data_ready  in  1  NoC accepts o_data.
- done  in  1  global stop; halts injection.

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - o_data_valid=0, o_data=0, o_data_ready=0;
  - cycle counter, tx_count, rx_count, lat_sum and lat_max=0; misroute=0;
  - LFSR loads seed 16'hACE1 XOR address.
- A reset asserted mid-operation aborts any pending flit; no handshake completes in a cycle where rst=1.
- Cycle counter: DataWidth bits, +1 every non-reset cycle, wraps modulo 2^DataWidth.
- Flit format:
  - o_data[TotalWidth-1:DataWidth] = destination address;
  - o_data[DataWidth-1:0] = value of the cycle counter in the cycle the flit was first presented.
- Transmit handshake:
  - Transfer occurs on a rising edge with o_data_valid=1 and i_data_ready=1.
  - While i_data_ready=0, o_data and o_data_valid stay stable.
  - The first flit is presented in the first cycle after rst deasserts.
  - After each transfer the next flit is presented in the following cycle, so back-to-back transfers give one flit per cycle.
- tx_count increments on each transfer. When tx_count reaches PktLmit, o_data_valid=0 permanently until the next reset.
- done=1 (sampled at a clock edge): o_data_valid drops to 0 in the next cycle and no further flits are presented. A flit handshaking in the same edge that done is sampled is still counted as sent.
- Destination generation (evaluated per new flit):
  - RANDOM: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, advances once per transfer. Candidate = lfsr[AddressWidth-1:0] mod numPE. If candidate == address, use (candidate+1) mod numPE.
  - NEIGHBOR: (address+1) mod numPE.
  - COMPLEMENT: (~address)[AddressWidth-1:0] mod numPE. If that equals address, use (address+1) mod numPE.
  - Any other Pattern string behaves as RANDOM.
  - A PE never addresses itself.
- Receive side:
  - o_data_ready=1 in every non-reset cycle, regardless of done.
  - Every cycle with i_data_valid=1 is one received flit; no backpressure.
  - On each received flit:
    - rx_count += 1 (32-bit, saturating);
    - latency = (cycle counter − i_data[DataWidth-1:0]) mod 2^DataWidth;
    - lat_sum += latency (48-bit, wrapping);
    - lat_max = max(lat_max, latency);
    - if i_data[TotalWidth-1:DataWidth] != address, set misroute (sticky until reset).
- tx_count, rx_count, lat_sum, lat_max and misroute are internal registers, hierarchically observable by the verification bench.

Test Plan:
- Reset, then i_data_ready held 1, Pattern=NEIGHBOR, address=2, numPE=4:
  - 100 consecutive transfers, every dest field = 3;
  - payload increments by 1 per flit;
  - o_data_valid=0 from cycle 101 onward.
- Backpressure: i_data_ready=0 for 5 cycles mid-stream:
  - o_data and o_data_valid stay unchanged throughout;
  - no flit lost or duplicated; tx_count ends at 100.
- Pattern=RANDOM, address=0, 100 transfers:
  - no dest equals 0; all dests in 1..3;
  - rerunning after reset reproduces the identical sequence.
- Receive path: drive i_data={2'd1, counter−7} with valid for 3 cycles into PE address=1:
  - rx_count=3, lat_max=7, lat_sum=21, misroute=0.
- Misroute: one flit with dest=3 into PE address=1 → misroute=1, and it stays 1 until rst.
- done asserted after 10 transfers → o_data_valid=0 the next cycle, tx_count=10, o_data_ready stays 1; then rst mid-stream → all counters 0 and injection restarts.
